// File: rtl/spi_follower_if.sv
// Host-side and SPI-pad signals of the SPI follower, bundled for port connection.
// The follower uses the slave view; whatever drives the host side and the SPI leader uses master.
interface spi_follower_if;
  logic        cfg_wr;
  logic [7:0]  cfg_data;
  logic [15:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_read;
  logic        overrun;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;

  modport slave (
    input  cfg_wr, cfg_data, tx_data, tx_load, rx_read, sclk, cs_n, mosi,
    output tx_ready, rx_data, rx_valid, overrun, busy, miso, miso_oe
  );

  modport master (
    output cfg_wr, cfg_data, tx_data, tx_load, rx_read, sclk, cs_n, mosi,
    input  tx_ready, rx_data, rx_valid, overrun, busy, miso, miso_oe
  );
endinterface

// File: rtl/spi_follower.sv
// SPI follower, modes 0-3, 8/16-bit words, bus oversampled on clk through a synchronizer chain.
// state | meaning:  IDLE | cs_n high, bus ignored;  ACTIVE | cs_n low, words shifting
module spi_follower #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_follower_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic        sclk_prev_q, cs_prev_q;
  logic        sclk_s, cs_s, mosi_s;
  logic        cpol_q, cpol_d, cpha_q, cpha_d, len_q, len_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [15:0] tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic        tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic        lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  logic        active, abort, do_sample, do_shift, word_start, word_done;
  logic [3:0]  last_bit;
  logic [15:0] rx_word, tx_word;
  logic        unused_bits;

  // cs_n chain resets low: a leader already holding cs_n low must release and re-assert it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge   = cpol_q ? (sclk_prev_q & ~sclk_s) : (sclk_s & ~sclk_prev_q);
  assign trail_edge  = cpol_q ? (sclk_s & ~sclk_prev_q) : (sclk_prev_q & ~sclk_s);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = cs_s & ~cs_prev_q;
  assign active      = (state_q == ACTIVE);
  assign abort       = active & cs_rise;
  assign last_bit    = len_q ? 4'd15 : 4'd7;
  assign do_sample   = active & ~cs_rise & sample_edge;
  assign word_done   = do_sample & (bit_cnt_q == last_bit);
  // A shift edge with the counter at zero opens a word; for cpha=0 that is the previous word's last one.
  assign do_shift    = active & ~cs_rise & shift_edge & (bit_cnt_q != 4'd0);
  assign word_start  = (~active & cs_fall & ~cpha_q) |
                       (active & ~cs_rise & shift_edge & (bit_cnt_q == 4'd0));
  assign rx_word     = len_q ? {rx_sr_q[14:0], mosi_s} : {8'h00, rx_sr_q[6:0], mosi_s};
  assign tx_word     = len_q ? tx_buf_q : {tx_buf_q[7:0], 8'h00};
  assign unused_bits = ^{bus.cfg_data[7], bus.cfg_data[3:0], rx_sr_q[15]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = active;
    bus.miso_oe  = active;
    bus.miso     = active & tx_sr_q[15];
    bus.tx_ready = ~tx_full_q;
    bus.rx_data  = rx_data_q;
    bus.rx_valid = rx_valid_q;
    bus.overrun  = overrun_q;
  end

  always_comb begin
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;

    if (word_start) begin
      tx_sr_d   = tx_full_q ? tx_word : 16'hFFFF;
      tx_full_d = 1'b0;
    end else if (do_shift) begin
      tx_sr_d = {tx_sr_q[14:0], 1'b0};
    end
    if (bus.tx_load && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    if (do_sample) begin
      rx_sr_d   = {rx_sr_q[14:0], mosi_s};
      bit_cnt_d = word_done ? 4'd0 : bit_cnt_q + 4'd1;
    end
    if (word_done) begin
      rx_data_d  = rx_word;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !bus.rx_read) overrun_d = 1'b1;
    end else if (bus.rx_read) begin
      rx_valid_d = 1'b0;
    end

    if (abort) begin
      bit_cnt_d = 4'd0;
      rx_sr_d   = '0;
      tx_sr_d   = '0;
    end

    if (!active && bus.cfg_wr) begin
      len_d     = bus.cfg_data[6];
      cpol_d    = bus.cfg_data[5];
      cpha_d    = bus.cfg_data[4];
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      len_q      <= 1'b0;
      bit_cnt_q  <= 4'd0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      len_q      <= len_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_follower.sv
// Bench for spi_follower: the leader and host are driven from tasks, and a word-level model
// of the follower supplies every expected value.
module tb_spi_follower;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst;
  spi_follower_if dif ();

  spi_follower #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(dif));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bit          m_cpol, m_cpha, m_len, m_full, m_rx_valid, m_overrun;
  logic [15:0] m_buf, m_rx_data, cur_tx;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cpol = 0; m_cpha = 0; m_len = 0; m_full = 0;
    m_rx_valid = 0; m_overrun = 0;
    m_buf = '0; m_rx_data = '0; cur_tx = '0;
  endtask

  // A word opening takes the buffered word, or all ones when nothing is buffered.
  task automatic model_start();
    if (m_full) cur_tx = m_len ? m_buf : {8'h00, m_buf[7:0]};
    else        cur_tx = 16'hFFFF;
    m_full = 0;
  endtask

  task automatic model_complete(input logic [15:0] w);
    if (m_rx_valid) m_overrun = 1;
    m_rx_valid = 1;
    m_rx_data  = m_len ? w : {8'h00, w[7:0]};
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("rx_data",  dif.rx_data, m_rx_data);
      chk("rx_valid", 16'(dif.rx_valid), 16'(m_rx_valid));
      chk("overrun",  16'(dif.overrun), 16'(m_overrun));
      chk("tx_ready", 16'(dif.tx_ready), 16'(!m_full));
      chk("busy_idle", 16'(dif.busy), 16'd0);
      chk("miso_oe_idle", 16'(dif.miso_oe), 16'd0);
      chk("miso_idle", 16'(dif.miso), 16'd0);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic do_cfg(input logic [7:0] d, input bit applies);
    @(posedge clk); #1;
    dif.cfg_data = d;
    dif.cfg_wr   = 1;
    @(posedge clk); #1;
    dif.cfg_wr = 0;
    if (applies) begin
      m_len = d[6]; m_cpol = d[5]; m_cpha = d[4]; m_overrun = 0;
      dif.sclk = m_cpol;
    end
  endtask

  task automatic do_tx(input logic [15:0] d);
    @(posedge clk); #1;
    dif.tx_data = d;
    dif.tx_load = 1;
    @(posedge clk); #1;
    dif.tx_load = 0;
    if (!m_full) begin m_full = 1; m_buf = d; end
  endtask

  task automatic do_rx_read();
    @(posedge clk); #1;
    dif.rx_read = 1;
    @(posedge clk); #1;
    dif.rx_read = 0;
    m_rx_valid = 0;
  endtask

  // Leader: nw words, the last one cut to last_bits; returns the miso bits it sampled.
  task automatic spi_xfer(input int nw, input logic [15:0] mw0, input logic [15:0] mw1,
                          input int last_bits, output logic [15:0] got0, output logic [15:0] got1);
    int n;
    logic [15:0] wd, got, expw;
    n = m_len ? 16 : 8;
    got0 = '0; got1 = '0;
    chk_en = 0;
    dif.sclk = m_cpol;
    wait_clks(4);
    dif.cs_n = 0;
    if (!m_cpha) model_start();
    wait_clks(HALF);
    for (int w = 0; w < nw; w++) begin
      int bits;
      bits = (w == nw - 1) ? last_bits : n;
      wd = (w == 0) ? mw0 : mw1;
      got = '0; expw = '0;
      for (int b = 0; b < bits; b++) begin
        if (!m_cpha) begin
          dif.mosi = wd[n-1-b];
          wait_clks(HALF);
          got  = {got[14:0], dif.miso};
          expw = {expw[14:0], cur_tx[n-1-b]};
          dif.sclk = ~m_cpol;
          wait_clks(HALF);
          dif.sclk = m_cpol;
        end else begin
          if (b == 0) model_start();
          dif.sclk = ~m_cpol;
          dif.mosi = wd[n-1-b];
          wait_clks(HALF);
          got  = {got[14:0], dif.miso};
          expw = {expw[14:0], cur_tx[n-1-b]};
          dif.sclk = m_cpol;
          wait_clks(HALF);
        end
      end
      if (bits == n) begin
        model_complete(wd);
        if (!m_cpha) model_start();
      end
      chk("miso_word", got, expw);
      if (w == 0) got0 = got; else got1 = got;
    end
    wait_clks(HALF);
    dif.cs_n = 1;
    wait_clks(8);
    chk_en = 1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] g0, g1;
    dif.cfg_wr = 0; dif.cfg_data = '0; dif.tx_data = '0; dif.tx_load = 0;
    dif.rx_read = 0; dif.sclk = 0; dif.cs_n = 1; dif.mosi = 0;
    rst = 1;
    model_reset();
    wait_clks(3);
    chk("rst_rx_data",  dif.rx_data, 16'h0000);
    chk("rst_rx_valid", 16'(dif.rx_valid), 16'd0);
    chk("rst_overrun",  16'(dif.overrun), 16'd0);
    chk("rst_tx_ready", 16'(dif.tx_ready), 16'd1);
    chk("rst_busy",     16'(dif.busy), 16'd0);
    chk("rst_miso_oe",  16'(dif.miso_oe), 16'd0);
    chk("rst_miso",     16'(dif.miso), 16'd0);
    rst = 0;
    wait_clks(6);
    chk_en = 1;

    // mode 0, 8-bit
    do_cfg(8'h00, 1);
    do_tx(16'h00A5);
    spi_xfer(1, 16'h003C, 16'h0000, 8, g0, g1);
    chk("m0_miso", g0, 16'h00A5);
    chk("m0_rx_data", dif.rx_data, 16'h003C);
    chk("m0_rx_valid", 16'(dif.rx_valid), 16'd1);
    do_rx_read();

    // cfg_wr while busy must not change the mode; empty buffer sends ones
    chk_en = 0;
    dif.cs_n = 0;
    wait_clks(8);
    chk("busy_low_cs", 16'(dif.busy), 16'd1);
    chk("miso_oe_busy", 16'(dif.miso_oe), 16'd1);
    model_start();
    do_cfg(8'h70, 0);
    dif.cs_n = 1;
    wait_clks(8);
    chk_en = 1;
    spi_xfer(1, 16'hABCD, 16'h0000, 8, g0, g1);
    chk("busy_cfg_miso_ones", g0, 16'h00FF);
    chk("busy_cfg_still_8bit", dif.rx_data, 16'h00CD);
    do_rx_read();

    // modes 1..3, 16-bit
    for (int md = 1; md < 4; md++) begin
      do_cfg(8'h40 | 8'(md << 4), 1);
      do_tx(16'h1234);
      spi_xfer(1, 16'hBEEF, 16'h0000, 16, g0, g1);
      chk("m123_miso", g0, 16'h1234);
      chk("m123_rx_data", dif.rx_data, 16'hBEEF);
      do_rx_read();
    end

    // back-to-back words without reading
    do_cfg(8'h00, 1);
    do_tx(16'h0011);
    spi_xfer(2, 16'h005A, 16'h00C3, 8, g0, g1);
    chk("b2b_miso0", g0, 16'h0011);
    chk("b2b_miso1", g1, 16'h00FF);
    chk("b2b_rx_data", dif.rx_data, 16'h00C3);
    chk("b2b_overrun", 16'(dif.overrun), 16'd1);
    do_cfg(8'h00, 1);
    chk("cfg_clears_overrun", 16'(dif.overrun), 16'd0);

    // cs_n raised after 5 bits
    do_rx_read();
    do_tx(16'h0077);
    spi_xfer(1, 16'h00F0, 16'h0000, 5, g0, g1);
    chk("abort_miso", g0, 16'h000E);
    chk("abort_rx_valid", 16'(dif.rx_valid), 16'd0);
    spi_xfer(1, 16'h0096, 16'h0000, 8, g0, g1);
    chk("after_abort_rx", dif.rx_data, 16'h0096);
    chk("after_abort_valid", 16'(dif.rx_valid), 16'd1);

    // reset in the middle of a mode-1 word with a word buffered
    do_cfg(8'h10, 1);
    chk_en = 0;
    do_tx(16'h00C3);
    dif.cs_n = 0;
    wait_clks(HALF);
    dif.sclk = 1; wait_clks(HALF);
    dif.sclk = 0; wait_clks(HALF);
    dif.sclk = 1; wait_clks(HALF);
    do_tx(16'h0055);
    chk("mid_tx_ready", 16'(dif.tx_ready), 16'd0);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("mrst_rx_data",  dif.rx_data, 16'h0000);
    chk("mrst_rx_valid", 16'(dif.rx_valid), 16'd0);
    chk("mrst_tx_ready", 16'(dif.tx_ready), 16'd1);
    chk("mrst_busy",     16'(dif.busy), 16'd0);
    chk("mrst_miso_oe",  16'(dif.miso_oe), 16'd0);
    chk("mrst_miso",     16'(dif.miso), 16'd0);
    model_reset();
    wait_clks(3);
    rst = 0;
    wait_clks(10);
    chk("held_cs_stays_idle", 16'(dif.busy), 16'd0);
    dif.sclk = 0;
    wait_clks(4);
    dif.cs_n = 1;
    wait_clks(8);
    chk_en = 1;
    do_tx(16'h005A);
    spi_xfer(1, 16'h0081, 16'h0000, 8, g0, g1);
    chk("post_rst_miso", g0, 16'h005A);
    chk("post_rst_rx", dif.rx_data, 16'h0081);

    // randomized transactions
    for (int it = 0; it < 40; it++) begin
      int nw, n, last;
      logic [15:0] r0, r1;
      do_cfg(8'($urandom), 1);
      if ($urandom_range(0, 1) == 1) do_tx(16'($urandom));
      if ($urandom_range(0, 2) == 0) do_rx_read();
      nw = $urandom_range(1, 2);
      n = m_len ? 16 : 8;
      last = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : n;
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      spi_xfer(nw, r0, r1, last, g0, g1);
    end

    wait_clks(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
